prng_lfsr_checker: RTL

- Receive side of the serial PRNG link: consumes the 1-bit `lfsr` stream and its `valid` qualifier from `prng_lfsr` (or from a channel carrying it).
- Deserializes the stream into symbols of run-time width `mode`, self-seeds a local LFSR from the first received symbol, then predicts and checks every following bit.
- Reports lock state, per-bit errors and saturating error/symbol counts.
- Sits at the sink end of link and BIST paths.

---
 rtl/prng_lfsr_checker_if.sv | 28 ++
 rtl/prng_lfsr_checker.sv | 89 ++++++++
 2 files changed

// File: rtl/prng_lfsr_checker_if.sv
// prng_lfsr_checker_if: configuration, serial stream and status bundle of the PRNG stream checker.
interface prng_lfsr_checker_if #(
  parameter int MAXSYMBOLWIDTH = 128,
  parameter int CNTWIDTH       = 32
);
  localparam int MW = $clog2(MAXSYMBOLWIDTH) + 1;
  logic                      load_mode;
  logic [MW-1:0]             mode;
  logic [MAXSYMBOLWIDTH-1:0] taps;
  logic                      valid;
  logic                      lfsr;
  logic                      clear_counts;
  logic                      symbol_valid;
  logic [MAXSYMBOLWIDTH-1:0] symbol;
  logic                      locked;
  logic                      bit_error;
  logic [CNTWIDTH-1:0]       error_count;
  logic [CNTWIDTH-1:0]       symbol_count;
  logic                      config_err;
  modport master (
    output load_mode, mode, taps, valid, lfsr, clear_counts,
    input  symbol_valid, symbol, locked, bit_error, error_count, symbol_count, config_err
  );
  modport slave (
    input  load_mode, mode, taps, valid, lfsr, clear_counts,
    output symbol_valid, symbol, locked, bit_error, error_count, symbol_count, config_err
  );
endinterface

// File: rtl/prng_lfsr_checker.sv
// prng_lfsr_checker: deserializes a serial LFSR stream, self-seeds from the first symbol, then checks every bit.
module prng_lfsr_checker #(
  parameter int MAXSYMBOLWIDTH = 128,
  parameter int LOSS_THRESH    = 4,
  parameter int CNTWIDTH       = 32
) (
  input logic               clock,
  input logic               resetn,
  prng_lfsr_checker_if.slave bus
);
  localparam int N  = MAXSYMBOLWIDTH;
  localparam int KW = $clog2(N);
  localparam int MW = KW + 1;
  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;
  state_t              state_q;
  logic [MW-1:0]       mode_q, tally_q, tally_d;
  logic [KW-1:0]       k_q;
  logic [N-1:0]        taps_q, s_q, acc_q, acc_d, symbol_q, mask_d;
  logic [CNTWIDTH-1:0] err_cnt_q, sym_cnt_q;
  logic                symbol_valid_q, locked_q, bit_error_q, config_err_q;
  logic                legal, active, pred, err, last, loss;
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < N; i++) mask_d[i] = i < int'(bus.mode);
    legal = bus.mode >= MW'(2) && bus.mode <= MW'(N);
    active = bus.valid && !bus.load_mode && state_q != IDLE;
    pred = ^(s_q & taps_q);
    err = active && state_q == CHECK && bus.lfsr != pred;
    last = MW'(k_q) == mode_q - MW'(1);
    tally_d = tally_q + MW'(err);
    loss = tally_d >= MW'(LOSS_THRESH);
    acc_d = acc_q;
    acc_d[k_q] = bus.lfsr;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q <= '0;
      taps_q <= '0;
      s_q <= '0;
      k_q <= '0;
      tally_q <= '0;
      acc_q <= '0;
      symbol_q <= '0;
      symbol_valid_q <= 1'b0;
      locked_q <= 1'b0;
      bit_error_q <= 1'b0;
      config_err_q <= 1'b0;
      err_cnt_q <= '0;
      sym_cnt_q <= '0;
    end else begin
      symbol_valid_q <= 1'b0;
      bit_error_q <= err;
      err_cnt_q <= bus.clear_counts ? '0 : (err && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
      sym_cnt_q <= bus.clear_counts ? '0 :
                   (active && last && state_q == CHECK && !(&sym_cnt_q)) ? sym_cnt_q + 1'b1 : sym_cnt_q;
      if (bus.load_mode) begin
        // acc is cleared here so bits above mode_q stay zero in every emitted symbol
        mode_q <= bus.mode;
        taps_q <= bus.taps & mask_d;
        s_q <= '0;
        k_q <= '0;
        tally_q <= '0;
        acc_q <= '0;
        config_err_q <= !legal;
        state_q <= legal ? SEED : IDLE;
        locked_q <= 1'b0;
      end else if (active) begin
        s_q <= {s_q[N-2:0], bus.lfsr};
        acc_q <= acc_d;
        k_q <= last ? '0 : k_q + 1'b1;
        tally_q <= last ? '0 : tally_d;
        if (last) begin
          symbol_q <= acc_d;
          symbol_valid_q <= 1'b1;
          state_q <= (state_q == SEED || !loss) ? CHECK : SEED;
          locked_q <= state_q == SEED || !loss;
        end
      end
    end
  end
  assign bus.symbol_valid = symbol_valid_q;
  assign bus.symbol       = symbol_q;
  assign bus.locked       = locked_q;
  assign bus.bit_error    = bit_error_q;
  assign bus.error_count  = err_cnt_q;
  assign bus.symbol_count = sym_cnt_q;
  assign bus.config_err   = config_err_q;
endmodule
